// File: rtl/epmp_alu_ext_if.sv
// epmp_alu_ext_if: control/status bundle between the EPMP control unit and the
// accumulator ALU.
//   master (control unit): drives ALU_En, ALU_Cmd, ACC_Out_En; observes flags/status.
//   slave  (ALU)         : receives the controls; drives C, Z, N, Busy, Done, Debug_*.
// The shared ACC_bus is a true tristate net and stays a plain inout on the ALU.
interface epmp_alu_ext_if #(
  parameter int unsigned WIDTH = 8
);
  logic             ALU_En;
  logic             ACC_Out_En;
  logic [3:0]       ALU_Cmd;
  logic             C;
  logic             Z;
  logic             N;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Debug_ACC;
  logic [WIDTH-1:0] Debug_AUX;

  modport master (
    output ALU_En, ACC_Out_En, ALU_Cmd,
    input  C, Z, N, Busy, Done, Debug_ACC, Debug_AUX
  );

  modport slave (
    input  ALU_En, ACC_Out_En, ALU_Cmd,
    output C, Z, N, Busy, Done, Debug_ACC, Debug_AUX
  );
endinterface

// File: rtl/epmp_alu_ext.sv
// epmp_alu_ext: WIDTH-bit accumulator ALU with C/Z/N flags, shift/rotate/compare/XOR
// and an optional multi-cycle unsigned shift-add multiplier (opcode 15).
// Ports:
//   clk      - system clock, all state on the rising edge
//   Reset_n  - asynchronous active-low reset
//   alu      - epmp_alu_ext_if.slave: ALU_En, ALU_Cmd, ACC_Out_En in;
//              C, Z, N, Busy, Done, Debug_ACC, Debug_AUX out
//   ACC_bus  - shared operand-in / ACC-out bus, high-Z unless ACC_Out_En
// Build option: define EPMP_ALU_MUL_EN to enable MUL; otherwise opcode 15 is a NOP
// and Busy/Done/Debug_AUX are tied low.
module epmp_alu_ext #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             Reset_n,
  epmp_alu_ext_if.slave    alu,
  inout  wire  [WIDTH-1:0] ACC_bus
);
  localparam logic [3:0] OpAdd = 4'd0,  OpSub = 4'd1,  OpClr = 4'd2,  OpNeg = 4'd3;
  localparam logic [3:0] OpInr = 4'd4,  OpDcr = 4'd5,  OpAnd = 4'd6,  OpOr  = 4'd7;
  localparam logic [3:0] OpLd  = 4'd8,  OpXor = 4'd9,  OpShl = 4'd10, OpShr = 4'd11;
  localparam logic [3:0] OpRol = 4'd12, OpRor = 4'd13, OpCmp = 4'd14, OpMul = 4'd15;

  logic [WIDTH-1:0] acc_q;
  logic             c_q, z_q, n_q;
  logic [WIDTH-1:0] b, res, flag_val;
  logic [WIDTH:0]   wide;
  logic             res_c, op_mul;

  // With ACC_Out_En set the operand read back is our own ACC (LOAD is then a no-op).
  assign ACC_bus = alu.ACC_Out_En ? acc_q : {WIDTH{1'bz}};
  assign b       = ACC_bus;

  // Single-cycle result and carry for the current command.
  always_comb begin
    wide   = '0;
    res    = acc_q;
    res_c  = c_q;
    op_mul = 1'b0;
    unique case (alu.ALU_Cmd)
      OpAdd: begin
        wide  = {1'b0, acc_q} + {1'b0, b} + {{WIDTH{1'b0}}, c_q};
        res   = wide[WIDTH-1:0];
        res_c = wide[WIDTH];
      end
      OpSub: begin
        wide  = {1'b0, acc_q} - {1'b0, b} - {{WIDTH{1'b0}}, c_q};
        res   = wide[WIDTH-1:0];
        res_c = wide[WIDTH];
      end
      OpClr: res = '0;
      OpNeg: begin res = '0 - acc_q;          res_c = 1'b0;         end
      OpInr: begin res = acc_q + WIDTH'(1);   res_c = &acc_q;       end
      OpDcr: begin res = acc_q - WIDTH'(1);   res_c = ~|acc_q;      end
      OpAnd: begin res = acc_q & b;           res_c = 1'b0;         end
      OpOr:  begin res = acc_q | b;           res_c = 1'b0;         end
      OpLd:  res = b;
      OpXor: begin res = acc_q ^ b;           res_c = 1'b0;         end
      OpShl: begin res = {acc_q[WIDTH-2:0], 1'b0}; res_c = acc_q[WIDTH-1]; end
      OpShr: begin res = {1'b0, acc_q[WIDTH-1:1]}; res_c = acc_q[0];       end
      OpRol: begin res = {acc_q[WIDTH-2:0], c_q};  res_c = acc_q[WIDTH-1]; end
      OpRor: begin res = {c_q, acc_q[WIDTH-1:1]};  res_c = acc_q[0];       end
      OpCmp: begin
        wide  = {1'b0, acc_q} - {1'b0, b};
        res_c = wide[WIDTH];
      end
      OpMul: op_mul = 1'b1;
    endcase
    // CMP leaves ACC alone but reports Z/N of the difference.
    flag_val = (alu.ALU_Cmd == OpCmp) ? wide[WIDTH-1:0] : res;
  end

  assign alu.C         = c_q;
  assign alu.Z         = z_q;
  assign alu.N         = n_q;
  assign alu.Debug_ACC = acc_q;

`ifdef EPMP_ALU_MUL_EN
  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mq_q, md_q, aux_q, mq_shift;
  logic [WIDTH:0]   p_q, p_sum, p_shift;
  logic [CntW-1:0]  cnt_q;
  logic             done_q;

  // One shift-add step: conditional add, then {P,MQ} >> 1.
  always_comb begin
    p_sum    = p_q + (mq_q[0] ? {1'b0, md_q} : '0);
    p_shift  = {1'b0, p_sum[WIDTH:1]};
    mq_shift = {p_sum[0], mq_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      aux_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      mq_q    <= '0;
      md_q    <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (alu.ALU_En) begin
            if (op_mul) begin
              mq_q    <= b;
              md_q    <= acc_q;
              p_q     <= '0;
              cnt_q   <= '0;
              state_q <= StMul;
            end else begin
              acc_q <= res;
              c_q   <= res_c;
              z_q   <= (flag_val == '0);
              n_q   <= flag_val[WIDTH-1];
            end
          end
        end
        StMul: begin
          p_q   <= p_shift;
          mq_q  <= mq_shift;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            acc_q   <= mq_shift;
            aux_q   <= p_shift[WIDTH-1:0];
            c_q     <= |p_shift[WIDTH-1:0];
            z_q     <= ~|{p_shift, mq_shift};
            n_q     <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu.Busy      = (state_q == StMul);
  assign alu.Done      = done_q;
  assign alu.Debug_AUX = aux_q;
`else
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_q <= '0;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
    end else if (alu.ALU_En && !op_mul) begin
      acc_q <= res;
      c_q   <= res_c;
      z_q   <= (flag_val == '0);
      n_q   <= flag_val[WIDTH-1];
    end
  end

  assign alu.Busy      = 1'b0;
  assign alu.Done      = 1'b0;
  assign alu.Debug_AUX = '0;
`endif
endmodule

// File: tb/tb_epmp_alu_ext.sv
module tb_epmp_alu_ext;
  localparam int unsigned W = 8;

  typedef struct {
    logic [3:0]  cmd;
    logic [7:0]  b;
    logic [10:0] want;  // {acc, c, z, n}
  } vec_t;

  logic clk = 1'b0;
  logic Reset_n;
  always #5 clk = ~clk;

  epmp_alu_ext_if #(.WIDTH(W)) alu_if ();

  wire  [W-1:0] acc_bus;
  logic [W-1:0] tb_b;
  logic         tb_drv;
  assign acc_bus = tb_drv ? tb_b : {W{1'bz}};

  epmp_alu_ext #(.WIDTH(W)) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .alu     (alu_if),
    .ACC_bus (acc_bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  m_acc, m_aux;
  logic        m_c, m_z, m_n;
  logic [10:0] sb[$];

  function automatic logic [10:0] obs();
    return {alu_if.Debug_ACC, alu_if.C, alu_if.Z, alu_if.N};
  endfunction

  task automatic model_reset();
    m_acc = 8'h00; m_aux = 8'h00; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
    sb.delete();
  endtask

  task automatic model(input logic [3:0] cmd, input logic [7:0] b);
    int d;
    logic [7:0] r;
    r = m_acc;
    case (cmd)
      4'd0: begin d = int'(m_acc) + int'(b) + int'(m_c); m_c = (d > 255); r = d[7:0]; end
      4'd1: begin d = int'(m_acc) - int'(b) - int'(m_c); m_c = (d < 0); r = d[7:0]; end
      4'd2: r = 8'h00;
      4'd3: begin d = -int'(m_acc); r = d[7:0]; m_c = 1'b0; end
      4'd4: begin m_c = (m_acc == 8'hFF); r = m_acc + 8'd1; end
      4'd5: begin m_c = (m_acc == 8'h00); r = m_acc - 8'd1; end
      4'd6: begin r = m_acc & b; m_c = 1'b0; end
      4'd7: begin r = m_acc | b; m_c = 1'b0; end
      4'd8: r = b;
      4'd9: begin r = m_acc ^ b; m_c = 1'b0; end
      4'd10: begin r = m_acc << 1; m_c = m_acc[7]; end
      4'd11: begin r = m_acc >> 1; m_c = m_acc[0]; end
      4'd12: begin r = {m_acc[6:0], m_c}; m_c = m_acc[7]; end
      4'd13: begin r = {m_c, m_acc[7:1]}; m_c = m_acc[0]; end
      4'd14: begin
        d = int'(m_acc) - int'(b);
        m_c = (d < 0);
        r = d[7:0];
        m_z = (r == 8'h00);
        m_n = r[7];
        return;
      end
      default: return;  // opcode 15 without the multiplier: nothing changes
    endcase
    m_acc = r;
    m_z = (r == 8'h00);
    m_n = r[7];
  endtask

  task automatic model_mul(input logic [7:0] b);
    int p;
    p = int'(m_acc) * int'(b);
    m_acc = p[7:0];
    m_aux = p[15:8];
    m_c = (m_aux != 8'h00);
    m_z = (p == 0);
    m_n = 1'b0;
  endtask

  // One command cycle: drive, clock, push expectation, return at the falling edge.
  task automatic drive(input logic [3:0] cmd, input logic [7:0] b, input logic en,
                       input logic oe);
    alu_if.ALU_Cmd = cmd;
    alu_if.ALU_En = en;
    alu_if.ACC_Out_En = oe;
    tb_drv = !oe;
    tb_b = b;
    @(posedge clk);
    if (en) model(cmd, oe ? m_acc : b);
    sb.push_back({m_acc, m_c, m_z, m_n});
    @(negedge clk);
    alu_if.ALU_En = 1'b0;
    alu_if.ACC_Out_En = 1'b0;
    tb_drv = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    @(negedge clk);
    total++;
    if (obs() !== 11'h000 || alu_if.Busy !== 1'b0 || alu_if.Done !== 1'b0) begin
      bad++;
      $display("FAIL reset_init: got acc/czn=%h busy=%b done=%b want 000 0 0",
               obs(), alu_if.Busy, alu_if.Done);
    end
    Reset_n = 1'b1;
    drive(4'd8, 8'h5A, 1'b1, 1'b0);
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++; $display("FAIL reset_load: got %h want %h", obs(), e);
    end
    // Asynchronous assertion mid-cycle, away from any clock edge.
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (obs() !== 11'h000 || alu_if.Busy !== 1'b0 || alu_if.Debug_AUX !== 8'h00) begin
      bad++;
      $display("FAIL reset_async: got acc/czn=%h busy=%b aux=%h want 000 0 00",
               obs(), alu_if.Busy, alu_if.Debug_AUX);
    end
    alu_if.ACC_Out_En = 1'b1;
    tb_drv = 1'b0;
    #1;
    total++;
    if (acc_bus !== 8'h00) begin
      bad++; $display("FAIL reset_bus: got %h want 00", acc_bus);
    end
    alu_if.ACC_Out_En = 1'b0;
    tb_drv = 1'b1;
    @(negedge clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_carry();
    vec_t v[3] = '{
      '{4'd8, 8'hFF, {8'hFF, 3'b001}},
      '{4'd0, 8'h01, {8'h00, 3'b110}},
      '{4'd0, 8'h00, {8'h01, 3'b000}}
    };
    logic [10:0] e;
    foreach (v[i]) begin
      drive(v[i].cmd, v[i].b, 1'b1, 1'b0);
      e = sb.pop_front();
      total++;
      if (obs() !== v[i].want || obs() !== e) begin
        bad++;
        $display("FAIL carry[%0d]: got %h want %h (model %h)", i, obs(), v[i].want, e);
      end
    end
  endtask

  task automatic test_borrow();
    vec_t v[4] = '{
      '{4'd8,  8'h10, {8'h10, 3'b000}},
      '{4'd14, 8'h20, {8'h10, 3'b101}},
      '{4'd6,  8'hFF, {8'h10, 3'b000}},
      '{4'd1,  8'h10, {8'h00, 3'b010}}
    };
    logic [10:0] e;
    foreach (v[i]) begin
      drive(v[i].cmd, v[i].b, 1'b1, 1'b0);
      e = sb.pop_front();
      total++;
      if (obs() !== v[i].want || obs() !== e) begin
        bad++;
        $display("FAIL borrow[%0d]: got %h want %h (model %h)", i, obs(), v[i].want, e);
      end
    end
  endtask

  task automatic test_shift_logic();
    vec_t v[14] = '{
      '{4'd8,  8'h81, {8'h81, 3'b001}},
      '{4'd12, 8'h00, {8'h02, 3'b100}},
      '{4'd13, 8'h00, {8'h81, 3'b001}},
      '{4'd11, 8'h00, {8'h40, 3'b100}},
      '{4'd10, 8'h00, {8'h80, 3'b001}},
      '{4'd10, 8'h00, {8'h00, 3'b110}},
      '{4'd8,  8'hFF, {8'hFF, 3'b101}},
      '{4'd4,  8'h00, {8'h00, 3'b110}},
      '{4'd5,  8'h00, {8'hFF, 3'b101}},
      '{4'd3,  8'h00, {8'h01, 3'b000}},
      '{4'd7,  8'h80, {8'h81, 3'b001}},
      '{4'd9,  8'hFF, {8'h7E, 3'b000}},
      '{4'd2,  8'h00, {8'h00, 3'b010}},
      '{4'd5,  8'h00, {8'hFF, 3'b101}}
    };
    logic [10:0] e;
    foreach (v[i]) begin
      drive(v[i].cmd, v[i].b, 1'b1, 1'b0);
      e = sb.pop_front();
      total++;
      if (obs() !== v[i].want || obs() !== e) begin
        bad++;
        $display("FAIL shift[%0d]: got %h want %h (model %h)", i, obs(), v[i].want, e);
      end
    end
  endtask

  task automatic test_bus_and_hold();
    logic [10:0] e;
    drive(4'd8, 8'hC3, 1'b1, 1'b0);
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin bad++; $display("FAIL self_pre: got %h want %h", obs(), e); end
    // LOAD from our own driven bus must leave ACC unchanged.
    drive(4'd8, 8'h00, 1'b1, 1'b1);
    e = sb.pop_front();
    total++;
    if (obs() !== e || alu_if.Debug_ACC !== 8'hC3) begin
      bad++; $display("FAIL self_load: got %h want %h", obs(), e);
    end
    alu_if.ACC_Out_En = 1'b1;
    tb_drv = 1'b0;
    #1;
    total++;
    if (acc_bus !== 8'hC3) begin bad++; $display("FAIL bus_drive: got %h want c3", acc_bus); end
    alu_if.ACC_Out_En = 1'b0;
    tb_drv = 1'b1;
    @(negedge clk);
    drive(4'd2, 8'h00, 1'b0, 1'b0);
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin bad++; $display("FAIL hold: got %h want %h", obs(), e); end
  endtask

  task automatic test_random();
    logic [10:0] e;
    logic [3:0] cmd;
    logic en, oe;
    for (int i = 0; i < 60; i++) begin
      cmd = 4'($urandom_range(0, 14));
      en = ($urandom_range(0, 3) != 0);
      oe = (cmd == 4'd8) && ($urandom_range(0, 1) == 1);
      drive(cmd, 8'($urandom), en, oe);
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin
        bad++; $display("FAIL random[%0d] cmd=%0d en=%b: got %h want %h", i, cmd, en, obs(), e);
      end
    end
  endtask

`ifdef EPMP_ALU_MUL_EN
  task automatic test_mul();
    logic [10:0] e;
    logic [7:0] pairs[8] = '{8'h37, 8'h00, 8'h0F, 8'h11, 8'h80, 8'h02, 8'hA5, 8'h5A};
    int cyc;
    drive(4'd8, 8'hFF, 1'b1, 1'b0);
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin bad++; $display("FAIL mul_load: got %h want %h", obs(), e); end
    alu_if.ALU_Cmd = 4'd15;
    alu_if.ALU_En = 1'b1;
    tb_b = 8'hFF;
    @(posedge clk);
    model_mul(8'hFF);
    sb.push_back({m_acc, m_c, m_z, m_n});
    @(negedge clk);
    alu_if.ALU_Cmd = 4'd2;  // CLR attempts while busy must be ignored
    alu_if.ALU_En = 1'b0;
    total++;
    if (alu_if.Busy !== 1'b1 || alu_if.Done !== 1'b0) begin
      bad++; $display("FAIL mul_start: got busy=%b done=%b want 1 0", alu_if.Busy, alu_if.Done);
    end
    for (int k = 1; k <= 8; k++) begin
      alu_if.ALU_En = (k % 2 == 0);
      if (k == 4) begin
        alu_if.ACC_Out_En = 1'b1;
        tb_drv = 1'b0;
        #1;
        total++;
        if (acc_bus !== 8'hFF) begin bad++; $display("FAIL mul_bus: got %h want ff", acc_bus); end
        alu_if.ACC_Out_En = 1'b0;
        tb_drv = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (k < 8) begin
        if (alu_if.Busy !== 1'b1 || alu_if.Done !== 1'b0 || alu_if.Debug_ACC !== 8'hFF) begin
          bad++;
          $display("FAIL mul_busy[%0d]: got busy=%b done=%b acc=%h want 1 0 ff", k,
                   alu_if.Busy, alu_if.Done, alu_if.Debug_ACC);
        end
      end else begin
        if (alu_if.Busy !== 1'b0 || alu_if.Done !== 1'b1) begin
          bad++;
          $display("FAIL mul_done: got busy=%b done=%b want 0 1", alu_if.Busy, alu_if.Done);
        end
      end
    end
    alu_if.ALU_En = 1'b0;
    e = sb.pop_front();
    total++;
    if (obs() !== e || obs() !== {8'h01, 3'b100} || alu_if.Debug_AUX !== 8'hFE) begin
      bad++;
      $display("FAIL mul_ff: got %h aux=%h want %h aux=fe", obs(), alu_if.Debug_AUX, e);
    end
    @(negedge clk);
    total++;
    if (alu_if.Done !== 1'b0) begin bad++; $display("FAIL mul_pulse: got done=1 want 0"); end
    for (int i = 0; i < 8; i += 2) begin
      drive(4'd8, pairs[i], 1'b1, 1'b0);
      void'(sb.pop_front());
      alu_if.ALU_Cmd = 4'd15;
      alu_if.ALU_En = 1'b1;
      tb_b = pairs[i+1];
      @(posedge clk);
      model_mul(pairs[i+1]);
      sb.push_back({m_acc, m_c, m_z, m_n});
      @(negedge clk);
      alu_if.ALU_En = 1'b0;
      cyc = 0;
      do begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end while (alu_if.Done !== 1'b1 && cyc < 20);
      e = sb.pop_front();
      total++;
      if (cyc != 8 || obs() !== e || alu_if.Debug_AUX !== m_aux) begin
        bad++;
        $display("FAIL mul[%0d]: got cyc=%0d %h aux=%h want cyc=8 %h aux=%h", i, cyc, obs(),
                 alu_if.Debug_AUX, e, m_aux);
      end
    end
  endtask

  task automatic test_mul_abort();
    logic seen_done;
    drive(4'd8, 8'h5A, 1'b1, 1'b0);
    void'(sb.pop_front());
    alu_if.ALU_Cmd = 4'd15;
    alu_if.ALU_En = 1'b1;
    tb_b = 8'h03;
    @(posedge clk);
    @(negedge clk);
    alu_if.ALU_En = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (obs() !== 11'h000 || alu_if.Busy !== 1'b0 || alu_if.Debug_AUX !== 8'h00) begin
      bad++;
      $display("FAIL abort_reset: got %h busy=%b aux=%h want 000 0 00", obs(), alu_if.Busy,
               alu_if.Debug_AUX);
    end
    @(negedge clk);
    Reset_n = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      seen_done |= alu_if.Done | alu_if.Busy;
    end
    total++;
    if (seen_done !== 1'b0 || obs() !== 11'h000) begin
      bad++; $display("FAIL abort_quiet: got done/busy seen=%b %h want 0 000", seen_done, obs());
    end
  endtask
`else
  task automatic test_nop();
    logic [10:0] e;
    drive(4'd8, 8'h37, 1'b1, 1'b0);
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin bad++; $display("FAIL nop_load: got %h want %h", obs(), e); end
    drive(4'd15, 8'hAA, 1'b1, 1'b0);
    e = sb.pop_front();
    total++;
    if (obs() !== e || alu_if.Debug_ACC !== 8'h37) begin
      bad++; $display("FAIL nop_hold: got %h want %h", obs(), e);
    end
    total++;
    if (alu_if.Busy !== 1'b0 || alu_if.Done !== 1'b0 || alu_if.Debug_AUX !== 8'h00) begin
      bad++;
      $display("FAIL nop_status: got busy=%b done=%b aux=%h want 0 0 00", alu_if.Busy,
               alu_if.Done, alu_if.Debug_AUX);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset_n = 1'b0;
    alu_if.ALU_En = 1'b0;
    alu_if.ALU_Cmd = 4'd0;
    alu_if.ACC_Out_En = 1'b0;
    tb_b = 8'h00;
    tb_drv = 1'b1;
    model_reset();
    test_reset();
    test_carry();
    test_borrow();
    test_shift_logic();
    test_bus_and_hold();
    test_random();
`ifdef EPMP_ALU_MUL_EN
    test_mul();
    test_mul_abort();
`else
    test_nop();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/epmp_alu_ext.md
# epmp_alu_ext

Parametrised accumulator ALU for the EPMP datapath: a WIDTH-bit accumulator with carry, zero and negative flags, extended shift/rotate/compare/XOR operations and an optional multi-cycle unsigned shift-add multiplier. It sits on the shared bidirectional accumulator bus and is sequenced by the control unit through ALU_En/ALU_Cmd. A Busy/Done handshake covers multi-cycle commands.

## Interface
- WIDTH, 8: accumulator, bus and AUX width (≥4)
- clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- ALU_En  in  1  execute ALU_Cmd at this edge (ignored while Busy)
- ACC_Out_En  in  1  drive ACC onto ACC_bus
- ALU_Cmd  in  4  operation code
- ACC_bus  inout  WIDTH  operand in / ACC out (Z when ACC_Out_En=0)
- C  out  1  carry/borrow flag
- Z  out  1  zero flag
- N  out  1  negative flag (result MSB)
- Busy  out  1  multi-cycle op in progress
- Done  out  1  one-cycle pulse on multi-cycle completion
- Debug_ACC  out  WIDTH  ACC copy
- Debug_AUX  out  WIDTH  AUX (product high half)

## Operation
- Opcodes (B = ACC_bus): 0 ADD ACC+B+C; 1 SUB ACC−B−C, C=borrow; 2 CLR; 3 NEG −ACC, C=0; 4 INR, C=(ACC was all-ones); 5 DCR, C=(ACC was 0); 6 AND, C=0; 7 OR, C=0; 8 LOAD ACC=B, C kept; 9 XOR, C=0; 10 SHL C←MSB, LSB←0; 11 SHR C←LSB, MSB←0; 12 ROL through C; 13 ROR through C; 14 CMP flags of ACC−B (no carry in), ACC unchanged; 15 MUL (see Configuration).
- ADD/SUB computed WIDTH+1 bits wide; C = bit WIDTH.
- Z,N updated on every executed op from the new ACC (CMP: from difference). CLR → Z=1,N=0.
- LOAD with ACC_Out_En=1 reloads ACC unchanged (legal; bus driven by this block).
- ALU_En=0: all state held.
- FSM: IDLE, MUL. IDLE→MUL on accepted MUL; MUL→IDLE when step counter reaches WIDTH−1.
- MUL start: latch multiplier B into MQ, multiplicand ACC into MD, clear partial product P (WIDTH+1 bits), counter=0.
- Each MUL cycle: if MQ[0], P+=MD; shift {P,MQ} right one bit.
- Completion: ACC ← low half, AUX ← high half, C ← (high half ≠ 0), Z from full 2·WIDTH product, N=0.

## Timing
- Reset (async, Reset_n=0): ACC=0, AUX=0, C=Z=N=0, Busy=0, Done=0, FSM=IDLE, counter=0; ACC_bus Z unless ACC_Out_En=1 (then drives 0).
- Single-cycle ops: result/flags visible after the executing edge; latency 1.
- MUL: accept edge T; Busy=1 from T+1 through T+WIDTH; at edge T+WIDTH ACC/AUX/flags update, Busy→0, Done=1 for that one cycle.
- Total MUL latency WIDTH cycles; next command accepted at edge T+WIDTH+1 earliest.
- While Busy: ALU_En and ALU_Cmd ignored, ACC/flags not altered, ACC_Out_En still drives old ACC.
- Reset_n asserted mid-MUL: operation aborted, no Done, all state to reset values.

## Configuration
- EPMP_ALU_MUL_EN defined: opcode 15 performs multi-cycle MUL as above; FSM, MQ/MD/P, AUX present.
- Not defined: opcode 15 is NOP (ACC and flags held); Busy, Done, Debug_AUX tied 0; no multiplier logic.

## Test plan
- Reset: drive Reset_n=0 mid-stream with ACC=0x5A → ACC=0, C=Z=N=0, Busy=0 immediately, no clock needed.
- Carry chain (WIDTH=8): LOAD 0xFF, ADD 0x01 → ACC=0x00, C=1, Z=1; ADD 0x00 → ACC=0x01, C=0.
- Borrow/compare: LOAD 0x10, CMP 0x20 → ACC=0x10, C=1, N=1, Z=0; SUB 0x10 with C=0 → ACC=0x00, Z=1.
- Shifts: LOAD 0x81, C=0; ROL → ACC=0x02, C=1; ROR → ACC=0x81, C=0; SHR → 0x40, C=1.
- MUL (macro on): LOAD 0xFF, MUL with B=0xFF → Busy 8 cycles, Done pulse, ACC=0x01, AUX=0xFE, C=1; ALU_En pulses during Busy ignored.
- MUL abort / macro off: Reset_n low at cycle 3 of MUL → no Done, ACC=0; with macro off, opcode 15 leaves ACC=0x37 and flags unchanged.
